// File: rtl/cpu_pkg.sv
// Shared opcode, instruction-field and FSM-state definitions
// for the ALU issue controller and its register file.
package cpu_pkg;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_RTYPE = 6'h01;
  localparam logic [5:0] OP_ITYPE = 6'h02;
  localparam logic [5:0] OP_J     = 6'h05;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two async read ports, one sync write port,
// r0 hardwired to zero, synchronous clear.
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Fetch/decode/issue sequencer feeding an external ALU.
// Define ALU_ISSUE_PERF_EN to add the retired-instruction counter.
module alu_issue_ctrl
  import cpu_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int PC_W        = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     alu_instruction,
  output logic [31:0]     alu_data1,
  output logic [31:0]     alu_data2,
  input  logic [31:0]     alu_result,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]     retired
`endif
);

  localparam logic [2:0] LAT_LAST = 3'(ALU_LATENCY - 1);

  state_t      state;
  logic [31:0] ir;
  logic [31:0] res;
  logic [2:0]  lat_cnt;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        is_alu;
  logic        is_rtype;
  logic        is_known;

  assign op = ir[OP_HI:OP_LO];
  assign rs = ir[RS_HI:RS_LO];
  assign rt = ir[RT_HI:RT_LO];
  assign rd = ir[RD_HI:RD_LO];

  assign imem_addr = pc;

  always_comb begin
    is_alu   = 1'b0;
    is_rtype = 1'b0;
    is_known = 1'b1;
    unique case (1'b1)
      op == OP_RTYPE: begin
        is_alu   = 1'b1;
        is_rtype = 1'b1;
      end
      op == OP_ITYPE: is_alu = 1'b1;
      op == OP_NOP,
      op == OP_J,
      op == OP_HALT: ;
      default: is_known = 1'b0;
    endcase
  end

  // Write-back is combinational off the WB state; ir and res are stable there.
  regfile u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_val),
    .rd2   (rt_val),
    .we    (state == S_WB && is_alu),
    .wa    (is_rtype ? rd : rt),
    .wd    (res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      ir              <= '0;
      res             <= '0;
      lat_cnt         <= '0;
      pc              <= '0;
      imem_req        <= 1'b0;
      alu_instruction <= '0;
      alu_data1       <= '0;
      alu_data2       <= '0;
      halted          <= 1'b0;
      illegal         <= 1'b0;
`ifdef ALU_ISSUE_PERF_EN
      retired         <= '0;
`endif
    end else begin
      illegal <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_valid && imem_req) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_alu) begin
            alu_instruction <= ir;
            alu_data1       <= rs_val;
            alu_data2       <= is_rtype ? rt_val
                                        : sext16(ir[IMM_HI:IMM_LO]);
            lat_cnt         <= '0;
            state           <= S_EXEC;
          end else begin
            illegal <= ~is_known;
            state   <= S_WB;
          end
        end
        S_EXEC: begin
          if (lat_cnt == LAT_LAST) begin
            res   <= alu_result;
            state <= S_WB;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        S_WB: begin
`ifdef ALU_ISSUE_PERF_EN
          retired <= retired + 32'd1;
`endif
          if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            pc <= (op == OP_J) ? ir[PC_W-1:0] : pc + PC_W'(1);
            if (run) begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_HALT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized scoreboard bench for alu_issue_ctrl with an adder ALU
// and a wait-state instruction memory.
module tb_alu_issue_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] alu_instruction;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [31:0] alu_result;
  logic [7:0]  pc;
  logic        halted;
  logic        illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] retired;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl #(.ALU_LATENCY(1), .PC_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_valid      (imem_valid),
    .imem_rdata      (imem_rdata),
    .alu_instruction (alu_instruction),
    .alu_data1       (alu_data1),
    .alu_data2       (alu_data2),
    .alu_result      (alu_result),
    .pc              (pc),
    .halted          (halted),
    .illegal         (illegal)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .retired         (retired)
`endif
  );

  // latency-1 ALU: result is valid in the single EXEC cycle
  assign alu_result = alu_data1 + alu_data2;

  localparam logic [31:0] HALT_W = 32'hFC000000;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input int s, input int t, input int d);
    return {OP_RTYPE, 5'(s), 5'(t), 5'(d), 11'd0};
  endfunction
  function automatic logic [31:0] mk_i(input int s, input int t, input int imm);
    return {OP_ITYPE, 5'(s), 5'(t), 16'(imm)};
  endfunction
  function automatic logic [31:0] mk_j(input int t);
    return {OP_J, 26'(t)};
  endfunction

  logic [31:0] mem [256];
  int          waits [512];
  int          fidx = 0;
  bit          mon_en = 1'b0;

  typedef struct {
    logic [7:0]  addr;
    int          cyc;
    logic [31:0] ins;
    logic [31:0] d1;
    logic [31:0] d2;
    int          ill;
  } ev_t;
  ev_t exp_q[$];
  int  exp_retired;

  // memory responder with per-fetch wait states
  initial begin : resp
    int         wcnt;
    logic [7:0] a0;
    wcnt = 0;
    a0 = '0;
    forever begin
      @(negedge clk);
      if (imem_valid) begin
        imem_valid = 1'b0;
      end else if (imem_req && !reset) begin
        if (wcnt == 0) a0 = imem_addr;
        else check("addr_stable", 32'(imem_addr), 32'(a0));
        if (wcnt >= waits[fidx & 511]) begin
          imem_rdata = mem[imem_addr];
          imem_valid = 1'b1;
          wcnt = 0;
          fidx++;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // monitor: each new fetch pops the expected state left by the previous instruction
  initial begin : mon
    logic prev_req;
    int   cyc;
    int   ill;
    ev_t  e;
    prev_req = 1'b0;
    cyc = 0;
    ill = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (imem_req && !prev_req) begin
        if (mon_en) begin
          if (exp_q.size() == 0) begin
            check("fetch_expected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("fetch_addr", 32'(imem_addr), 32'(e.addr));
            check("alu_instruction", alu_instruction, e.ins);
            check("alu_data1", alu_data1, e.d1);
            check("alu_data2", alu_data2, e.d2);
            if (e.cyc >= 0) check("instr_cycles", 32'(cyc), 32'(e.cyc));
            check("illegal_pulses", 32'(ill), 32'(e.ill));
          end
        end
        cyc = 0;
        ill = 0;
      end
      if (illegal) ill++;
      prev_req = imem_req;
    end
  end

  // architectural model: walk the program from pc 0 until HALT
  task automatic build_model();
    logic [31:0] r [32];
    logic [7:0]  p;
    logic [31:0] ti, t1, t2, ins;
    logic [5:0]  o;
    int          pcyc, pill, dst;
    ev_t         e;
    for (int i = 0; i < 32; i++) r[i] = '0;
    p = '0; ti = '0; t1 = '0; t2 = '0;
    pcyc = -1; pill = 0;
    exp_retired = 0;
    for (int k = 0; k < 400; k++) begin
      ins = mem[p];
      e.addr = p; e.cyc = pcyc; e.ins = ti;
      e.d1 = t1; e.d2 = t2; e.ill = pill;
      exp_q.push_back(e);
      exp_retired++;
      o = ins[31:26];
      pill = 0;
      if (o == 6'h01 || o == 6'h02) begin
        ti = ins;
        t1 = r[ins[25:21]];
        t2 = (o == 6'h01) ? r[ins[20:16]] : 32'($signed(ins[15:0]));
        dst = (o == 6'h01) ? int'(ins[15:11]) : int'(ins[20:16]);
        if (dst != 0) r[dst] = t1 + t2;
        pcyc = waits[k] + 4;
        p = p + 8'd1;
      end else if (o == 6'h05) begin
        pcyc = waits[k] + 3;
        p = ins[7:0];
      end else if (o == 6'h3F) begin
        break;
      end else begin
        pill = (o != 6'h00) ? 1 : 0;
        pcyc = waits[k] + 3;
        p = p + 8'd1;
      end
    end
  endtask

  task automatic wait_halt(input string name);
    for (int i = 0; i < 5000 && !halted; i++) @(negedge clk);
    check(name, 32'(halted), 32'd1);
  endtask

  task automatic wait_instr(input string name, input logic [31:0] w);
    for (int i = 0; i < 200 && alu_instruction !== w; i++) @(negedge clk);
    check(name, alu_instruction, w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fidx = 0;
  endtask

  initial begin
    int sel, hi_cnt;
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    for (int i = 0; i < 512; i++) waits[i] = 0;

    // reset during EXEC of an R-type
    mem[0] = 32'h04221000;
    do_reset();
    run = 1'b1;
    wait_instr("reach_exec", 32'h04221000);
    reset = 1'b1;
    run = 1'b0;
    @(negedge clk);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_alu_instr", alu_instruction, 32'd0);
    check("rst_alu_d1", alu_data1, 32'd0);
    check("rst_alu_d2", alu_data2, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    check("rst_retired", retired, 32'd0);
`endif
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_no_req", 32'(imem_req), 32'd0);

    // directed prefix then random body
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    mem[0] = 32'h0801000A;
    mem[1] = 32'h04211000;
    mem[2] = mk_r(2, 1, 3);
    mem[3] = mk_j(6);
    mem[6] = 32'h1C000000;
    mem[7] = 32'h08000007;
    mem[8] = mk_r(0, 0, 4);
    for (int i = 9; i < 49; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)
        mem[i] = mk_r($urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7));
      else if (sel < 8)
        mem[i] = mk_i($urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 65535));
      else if (sel == 8)
        mem[i] = 32'h0;
      else
        mem[i] = {6'($urandom_range(8, 60)), 26'($urandom)};
    end
    for (int i = 0; i < 512; i++) waits[i] = $urandom_range(0, 2);
    waits[2] = 3;
    do_reset();
    exp_q.delete();
    build_model();
    mon_en = 1'b1;
    run = 1'b1;
    wait_halt("halt_reached");
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req || !halted) hi_cnt++;
    end
    check("halt_sticky_no_req", 32'(hi_cnt), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    check("retired_count", retired, 32'(exp_retired));
`endif

    // run dropped mid-instruction: finish it, then idle
    for (int i = 0; i < 512; i++) waits[i] = 0;
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    mem[0] = mk_i(0, 1, 5);
    mem[1] = mk_r(1, 1, 2);
    do_reset();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (12) @(negedge clk);
    check("stop_pc", 32'(pc), 32'd1);
    check("stop_no_req", 32'(imem_req), 32'd0);
    check("stop_alu_d2", alu_data2, 32'd5);
    run = 1'b1;
    wait_instr("resume_exec", mk_r(1, 1, 2));
    check("resume_d1", alu_data1, 32'd5);
    check("resume_d2", alu_data2, 32'd5);
    wait_halt("resume_halt");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
